// File: rtl/perceptron_pkg.sv
// Shared types and geometry for the perceptron predictor training path.
package perceptron_pkg;

    localparam int GHR_WIDTH        = 16;
    localparam int WEIGHT_NUM       = GHR_WIDTH + 1;
    localparam int WEIGHT_ENTRY_NUM = 32;
    localparam int IDX_W            = $clog2(WEIGHT_ENTRY_NUM);
    localparam int WEIGHT_W         = 8;
    localparam int SUM_W            = 13;
    localparam int THETA            = 44;
    localparam int ROW_W            = WEIGHT_NUM * WEIGHT_W;

    typedef logic signed [WEIGHT_W-1:0] weight_t;

    typedef struct packed {
        logic [IDX_W-1:0]        idx;
        logic [GHR_WIDTH-1:0]    ghr;
        logic signed [SUM_W-1:0] sum;
        logic                    outcome;
    } train_rec_t;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    localparam weight_t W_MAX = weight_t'({1'b0, {(WEIGHT_W-1){1'b1}}});
    localparam weight_t W_MIN = weight_t'({1'b1, {(WEIGHT_W-1){1'b0}}});

    // One saturating +/-1 step on a signed weight.
    function automatic weight_t sat_step(weight_t w, logic inc);
        if (inc)
            return (w == W_MAX) ? w : weight_t'(w + weight_t'(1));
        else
            return (w == W_MIN) ? w : weight_t'(w - weight_t'(1));
    endfunction

endpackage

// File: rtl/perceptron_train_fifo.sv
// Small in-order queue of resolved-branch records awaiting training.
module perceptron_train_fifo
    import perceptron_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  train_rec_t push_rec,
    input  logic       pop,
    output train_rec_t head,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);

    train_rec_t         mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;
    logic               do_push, do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_rec;
    end

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Read-modify-write training sequencer for the perceptron weight array.
// Optional PERCEPTRON_TRAIN_STATS_EN adds saturating train/skip counters.
module perceptron_train_ctrl
    import perceptron_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    res_valid,
    output logic                    res_ready,
    input  logic [IDX_W-1:0]        res_idx,
    input  logic [GHR_WIDTH-1:0]    res_ghr,
    input  logic signed [SUM_W-1:0] res_sum,
    input  logic                    res_outcome,
    input  logic                    lookup_valid,
    output logic                    arr_rd_en,
    output logic [IDX_W-1:0]        arr_rd_idx,
    input  logic [ROW_W-1:0]        arr_rd_data,
    output logic                    arr_wr_en,
    output logic [IDX_W-1:0]        arr_wr_idx,
    output logic [ROW_W-1:0]        arr_wr_data,
    output logic                    busy,
    output logic [15:0]             train_cnt,
    output logic [15:0]             skip_cnt
);

    train_rec_t push_rec, head;
    logic       fifo_full, fifo_empty, head_valid, pop;

    assign push_rec = '{idx: res_idx, ghr: res_ghr, sum: res_sum, outcome: res_outcome};

    perceptron_train_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (res_valid),
        .push_rec (push_rec),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign res_ready  = !fifo_full;
    assign head_valid = !fifo_empty;

    // Magnitude needs one extra bit so the most negative sum stays positive.
    logic signed [SUM_W:0] sum_ext, sum_abs;
    logic                  pred, train;

    assign sum_ext = {head.sum[SUM_W-1], head.sum};
    assign sum_abs = sum_ext[SUM_W] ? -sum_ext : sum_ext;
    assign pred    = !head.sum[SUM_W-1];
    assign train   = (pred != head.outcome) || (sum_abs <= (SUM_W+1)'(THETA));

    // x0 is the constant bias input; xi follows the history snapshot.
    logic [WEIGHT_NUM-1:0] x_bits;
    logic [ROW_W-1:0]      row_upd, row_q;

    assign x_bits = {head.ghr, 1'b1};

    for (genvar i = 0; i < WEIGHT_NUM; i++) begin : g_upd
        assign row_upd[i*WEIGHT_W +: WEIGHT_W] =
            sat_step(weight_t'(arr_rd_data[i*WEIGHT_W +: WEIGHT_W]), x_bits[i] == head.outcome);
    end

    state_t state, state_nxt;
    logic   rd_go, wr_go, skip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            row_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == RD) row_q <= row_upd;
        end
    end

    // Head stays in the FIFO until its write retires, so it remains stable across RD/WR.
    always_comb begin
        state_nxt = state;
        rd_go     = 1'b0;
        wr_go     = 1'b0;
        skip      = 1'b0;
        unique case (state)
            IDLE: begin
                if (head_valid) begin
                    if (!train) begin
                        skip = 1'b1;
                    end else if (!lookup_valid) begin
                        rd_go     = 1'b1;
                        state_nxt = RD;
                    end
                end
            end
            RD: state_nxt = WR;
            WR: begin
                if (!lookup_valid) begin
                    wr_go     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pop         = skip || wr_go;
    assign arr_rd_en   = rd_go;
    assign arr_rd_idx  = rd_go ? head.idx : '0;
    assign arr_wr_en   = wr_go;
    assign arr_wr_idx  = wr_go ? head.idx : '0;
    assign arr_wr_data = wr_go ? row_q : '0;
    assign busy        = head_valid || (state != IDLE);

`ifdef PERCEPTRON_TRAIN_STATS_EN
    logic [15:0] train_q, skip_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            train_q <= '0;
            skip_q  <= '0;
        end else begin
            if (wr_go && train_q != 16'hFFFF) train_q <= train_q + 1'b1;
            if (skip  && skip_q  != 16'hFFFF) skip_q  <= skip_q + 1'b1;
        end
    end

    assign train_cnt = train_q;
    assign skip_cnt  = skip_q;
`else
    assign train_cnt = '0;
    assign skip_cnt  = '0;
`endif

endmodule
